recovery_arbiter: RTL and testbench

RECOVERY_ARBITER -- requirements
Module: recovery_arbiter

---
 rtl/recovery_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/recovery_arbiter.sv | 129 ++++++++++++
 tb/tb_recovery_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recovery_pkg.sv
// Shared types and default sizing for the recovery arbiter.
package recovery_pkg;

  localparam int unsigned DefNumCores  = 4;
  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefNumReg    = 2 ** DefAddrWidth;
  localparam int unsigned DefTimeout   = 64;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StHalt,
    StHaltWait,
    StCopyPc,
    StCopyGpr,
    StResume,
    StAbort
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last_i+1 with wrap-around.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [$clog2(NUM_CORES)-1:0] last_i,
  output logic [$clog2(NUM_CORES)-1:0] gnt_o,
  output logic                         valid_o
);

  localparam int unsigned SelW = $clog2(NUM_CORES);

  int unsigned     w_idx;
  logic [SelW-1:0] w_cand;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    w_idx   = 0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      w_idx  = (32'(last_i) + i) % NUM_CORES;
      w_cand = SelW'(w_idx);
      if (!valid_o && req_i[w_cand]) begin
        valid_o = 1'b1;
        gnt_o   = w_cand;
      end
    end
  end

endmodule

// File: rtl/recovery_arbiter.sv
// Serialises per-core error recovery over one shared shadow-copy/replay datapath.
// Optional HALT_WAIT timeout and sticky fail flags: define RECOVERY_TIMEOUT_EN.
module recovery_arbiter
  import recovery_pkg::*;
#(
  parameter int unsigned NUM_CORES      = DefNumCores,
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeout
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CORES-1:0]         error_i,
  input  logic [NUM_CORES-1:0]         halted_i,
  output logic [NUM_CORES-1:0]         core_reset_o,
  output logic [NUM_CORES-1:0]         halt_o,
  output logic [NUM_CORES-1:0]         resume_o,
  output logic [$clog2(NUM_CORES)-1:0] sel_o,
  output logic                         we_spc_o,
  output logic                         we_sgpr_o,
  output logic [ADDR_WIDTH-1:0]        replay_addr_o,
  output logic                         busy_o,
  output logic [NUM_CORES-1:0]         fail_o
);

  localparam int unsigned SelW = $clog2(NUM_CORES);
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0]       TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrLast = '1;
`ifdef RECOVERY_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  state_e                r_state, w_state_nxt;
  logic [NUM_CORES-1:0]  r_pending, w_pending_nxt, w_err;
  logic [SelW-1:0]       r_sel, r_last, w_win;
  logic                  w_win_valid;
  logic [NUM_CORES-1:0]  w_sel_oh, w_win_oh;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TmoW-1:0]       r_tmo;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_rr (
    .req_i  (r_pending),
    .last_i (r_last),
    .gnt_o  (w_win),
    .valid_o(w_win_valid)
  );

  assign w_sel_oh = NUM_CORES'(1) << r_sel;
  assign w_win_oh = NUM_CORES'(1) << w_win;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:     if (w_win_valid) w_state_nxt = StGrant;
      StGrant:    w_state_nxt = StHalt;
      StHalt:     w_state_nxt = StHaltWait;
      StHaltWait: begin
        if (|(halted_i & w_sel_oh))           w_state_nxt = StCopyPc;
        else if (TmoEn && (r_tmo == TmoLast)) w_state_nxt = StAbort;
      end
      StCopyPc:   w_state_nxt = StCopyGpr;
      StCopyGpr:  if (r_addr == AddrLast) w_state_nxt = StResume;
      StResume:   w_state_nxt = StIdle;
      StAbort:    w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  // The core under service cannot re-queue itself until it is back in IDLE.
  always_comb begin
    w_err         = (r_state == StIdle) ? error_i : (error_i & ~w_sel_oh);
    w_pending_nxt = r_pending | w_err;
    if (r_state == StIdle && w_win_valid) w_pending_nxt = w_pending_nxt & ~w_win_oh;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_sel     <= '0;
      r_last    <= SelW'(NUM_CORES - 1);
      r_addr    <= '0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (r_state == StIdle && w_win_valid) begin
        r_sel  <= w_win;
        r_last <= w_win;
      end
      // Wraps to zero exactly as the service leaves COPY_GPR.
      if (r_state == StCopyGpr) r_addr <= r_addr + 1'b1;
      if (r_state == StHalt) r_tmo <= '0;
      else if (r_state == StHaltWait) r_tmo <= r_tmo + 1'b1;
    end
  end

`ifdef RECOVERY_TIMEOUT_EN
  logic [NUM_CORES-1:0] r_fail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fail <= '0;
    end else if (r_state == StHaltWait && w_state_nxt == StAbort) begin
      r_fail <= r_fail | w_sel_oh;
    end
  end

  assign fail_o = r_fail;
`else
  assign fail_o = '0;
`endif

  always_comb begin
    core_reset_o  = (r_state == StGrant)  ? w_sel_oh : '0;
    halt_o        = (r_state == StHalt)   ? w_sel_oh : '0;
    resume_o      = (r_state == StResume) ? w_sel_oh : '0;
    we_spc_o      = (r_state == StCopyPc);
    we_sgpr_o     = (r_state == StCopyGpr);
    replay_addr_o = r_addr;
    busy_o        = (r_state != StIdle);
    sel_o         = r_sel;
  end

endmodule

// File: tb/tb_recovery_arbiter.sv
// Scoreboard bench: transaction-level pending/round-robin model feeds expected grants to a monitor.
module tb_recovery_arbiter;

  localparam int N   = 4;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  error_i, halted_i;
  logic [N-1:0]  core_reset_o, halt_o, resume_o, fail_o;
  logic [1:0]    sel_o;
  logic          we_spc_o, we_sgpr_o, busy_o;
  logic [AW-1:0] replay_addr_o;

  always #5 clk = ~clk;

  recovery_arbiter #(
    .NUM_CORES     (N),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .error_i      (error_i),
    .halted_i     (halted_i),
    .core_reset_o (core_reset_o),
    .halt_o       (halt_o),
    .resume_o     (resume_o),
    .sel_o        (sel_o),
    .we_spc_o     (we_spc_o),
    .we_sgpr_o    (we_sgpr_o),
    .replay_addr_o(replay_addr_o),
    .busy_o       (busy_o),
    .fail_o       (fail_o)
  );

  typedef enum int {PIdle, PRst, PGrant, PHalt, PWait, PPc, PGpr, PResume, PAbort} ph_e;

  ph_e          cur_ph = PIdle;
  ph_e          nxt_ph = PIdle;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] m_pend = '0;
  int           m_last = N - 1;
  int           m_core = 0;
  logic [N-1:0] exp_fail = '0;
  int           sb_q[$];
  int           glog[$];
  int           mon_core = 0;
  int           force_dly = -1;
  bit           no_halt = 1'b0;
  bit           rst_req = 1'b0;
  bit           rst_pulse = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending set, round-robin order, masking of the core in service.
  initial begin
    int win;
    int c;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        m_pend   = '0;
        m_last   = N - 1;
        exp_fail = '0;
        sb_q.delete();
        nxt_ph   = PRst;
      end else if (cur_ph == PIdle || cur_ph == PRst) begin
        if (m_pend != 0) begin
          win = -1;
          for (int s = 1; s <= N; s++) begin
            c = (m_last + s) % N;
            if (win < 0 && m_pend[c]) win = c;
          end
          sb_q.push_back(win);
          m_last = win;
          m_core = win;
          m_pend = (m_pend | error_i) & ~(N'(1) << win);
          nxt_ph = PGrant;
        end else begin
          m_pend = m_pend | error_i;
        end
      end else begin
        m_pend = m_pend | (error_i & ~(N'(1) << m_core));
      end
    end
  end

  // Monitor: checks every cycle's outputs against the expected service phase.
  initial begin
    ph_e           ph, nx;
    int            k, w, dly;
    logic [N-1:0]  oh, e_cr, e_h, e_r;
    logic          e_spc, e_sgpr, e_busy, addr_care;
    logic [AW-1:0] e_addr;
    logic [23:0]   act, exp;
    halted_i = '0;
    k = 0;
    w = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (rst_pulse) begin
        rst_i     = 1'b0;
        rst_pulse = 1'b0;
      end
      ph = nxt_ph;
      nx = PIdle;
      e_cr = '0; e_h = '0; e_r = '0;
      e_spc = 1'b0; e_sgpr = 1'b0; e_busy = 1'b1;
      addr_care = 1'b0; e_addr = '0;
      if (ph == PRst) begin
        mon_core = 0;
        halted_i = '0;
      end
      if (ph == PGrant && sb_q.size() > 0) begin
        mon_core = sb_q.pop_front();
        glog.push_back(mon_core);
      end
      oh = N'(1) << mon_core;
      case (ph)
        PRst:    begin e_busy = 1'b0; addr_care = 1'b1; end
        PIdle:   e_busy = 1'b0;
        PGrant:  e_cr = oh;
        PHalt:   e_h = oh;
        PPc:     begin e_spc = 1'b1; addr_care = 1'b1; e_addr = '0; end
        PGpr:    begin e_sgpr = 1'b1; addr_care = 1'b1; e_addr = AW'(k); end
        PResume: e_r = oh;
        PAbort:  exp_fail = exp_fail | oh;
        default: ;
      endcase
      act = {core_reset_o, halt_o, resume_o, we_spc_o, we_sgpr_o, busy_o, fail_o,
             addr_care ? replay_addr_o : AW'(0)};
      exp = {e_cr, e_h, e_r, e_spc, e_sgpr, e_busy, exp_fail, e_addr};
      chk($sformatf("outputs ph=%s core=%0d", ph.name(), mon_core), 64'(act), 64'(exp));
      chk($sformatf("sel ph=%s", ph.name()), 64'(sel_o), 64'(mon_core));
      case (ph)
        PGrant: nx = PHalt;
        PHalt: begin
          w   = 0;
          dly = no_halt ? -1 : ((force_dly >= 0) ? force_dly : $urandom_range(0, 4));
          nx  = PWait;
        end
        PWait: begin
          if (dly >= 0 && w == dly) begin
            halted_i = oh;
            nx       = PPc;
          end
`ifdef RECOVERY_TIMEOUT_EN
          else if (w == TMO - 1) nx = PAbort;
`endif
          else begin
            w++;
            nx = PWait;
          end
        end
        PPc: begin
          k  = 0;
          nx = PGpr;
        end
        PGpr: begin
          if (rst_req && k == 10) begin
            rst_i     = 1'b1;
            rst_req   = 1'b0;
            rst_pulse = 1'b1;
          end
          nx = (k == NR - 1) ? PResume : PGpr;
          k++;
        end
        PResume, PAbort: begin
          halted_i = '0;
          nx       = PIdle;
        end
        default: nx = PIdle;
      endcase
      cur_ph = ph;
      nxt_ph = nx;
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (n) begin
      error_i = N'($urandom);
      @(negedge clk);
    end
    rst_i   = 1'b0;
    error_i = '0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    @(negedge clk);
    error_i = v;
    @(negedge clk);
    error_i = '0;
  endtask

  task automatic wait_ph(input ph_e p, input int core, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (cur_ph == p && mon_core == core) ok = 1'b1;
    end
    chk({"reach ", name}, 64'(ok), 64'(1));
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (cur_ph == PIdle && nxt_ph == PIdle && m_pend == 0 && sb_q.size() == 0) ok = 1'b1;
    end
    chk({"drain ", name}, 64'(ok), 64'(1));
  endtask

  task automatic chk_log(input string name, input int exp_q[$]);
    chk({name, " count"}, 64'(glog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s grant%0d", name, i), (i < glog.size()) ? 64'(glog[i]) : '1,
          64'(exp_q[i]));
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    error_i = '0;
    do_reset(3);
    repeat (5) @(negedge clk);

    // Single error on core 2, halted returned in the first HALT_WAIT cycle.
    glog.delete();
    force_dly = 0;
    pulse(4'b0100);
    wait_idle(200, "single");
    chk_log("single", '{2});
    #1 chk("single sel hold", 64'(sel_o), 64'(2));

    // Simultaneous errors serviced 0,1,3.
    do_reset(2);
    glog.delete();
    force_dly = -1;
    pulse(4'b1011);
    wait_idle(600, "multi");
    chk_log("multi", '{0, 1, 3});

    // Own error during COPY_GPR ignored; core 0 error queued.
    do_reset(2);
    glog.delete();
    pulse(4'b0010);
    wait_ph(PGpr, 1, 100, "core1 copy");
    pulse(4'b0011);
    wait_idle(400, "mask");
    chk_log("mask", '{1, 0});

    // Reset at COPY_GPR address 10 drops the pending core 1 request.
    do_reset(2);
    glog.delete();
    pulse(4'b1000);
    wait_ph(PGpr, 3, 100, "core3 copy");
    pulse(4'b0010);
    rst_req = 1'b1;
    wait_ph(PRst, 0, 100, "mid reset");
    repeat (20) @(negedge clk);
    chk_log("reset", '{3});

    // Random error traffic with random halt latency.
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      error_i = ($urandom_range(0, 6) == 0) ? N'($urandom_range(1, 15)) : '0;
    end
    @(negedge clk);
    error_i = '0;
    wait_idle(4000, "random");

    // Core never acknowledges the halt.
    do_reset(2);
    glog.delete();
    no_halt = 1'b1;
    pulse(4'b0001);
    wait_ph(PWait, 0, 20, "halt wait");
`ifdef RECOVERY_TIMEOUT_EN
    wait_idle(200, "abort");
    repeat (5) @(negedge clk);
    #1;
    chk("fail sticky", 64'(fail_o), 64'(4'b0001));
    chk("abort idle", 64'(busy_o), 64'(0));
`else
    repeat (100) @(negedge clk);
    #1;
    chk("hang busy", 64'(busy_o), 64'(1));
    chk("hang fail", 64'(fail_o), 64'(0));
`endif
    no_halt = 1'b0;
    do_reset(2);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
